// File: rtl/adlv_cpa_seq.sv
// Iterative carry-propagate resolver: turns a redundant (sum, carry) pair into
// a binary result, CHUNK bits per clock, carry held between chunks.
module adlv_cpa_seq #(
  parameter int unsigned W     = 23,
  parameter int unsigned CHUNK = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   s_in,
  input  logic [W-1:0]   e_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W+1:0]   res,
  output logic           busy
);

  localparam int unsigned NCH = (W + 1) / CHUNK;
  localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1;

  if ((W + 1) % CHUNK != 0) begin : g_bad_chunk
    $error("adlv_cpa_seq: (W+1) must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [W:0]      opa_q;
  logic [W:0]      opb_q;
  logic            carry_q;
  logic [CW-1:0]   cnt_q;
  logic [W+1:0]    res_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            busy_q;
  logic [CHUNK:0]  chunk_sum_d;

  // Operands shift right each RUN cycle, so the adder always reads the low slice.
  always_comb begin
    chunk_sum_d = '0;
    chunk_sum_d = {1'b0, opa_q[CHUNK-1:0]} + {1'b0, opb_q[CHUNK-1:0]}
                + {{CHUNK{1'b0}}, carry_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      opa_q       <= '0;
      opb_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      res_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            opa_q      <= {1'b0, s_in};
            opb_q      <= {e_in, 1'b0};
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          opa_q                          <= opa_q >> CHUNK;
          opb_q                          <= opb_q >> CHUNK;
          res_q[cnt_q*CHUNK +: CHUNK]    <= chunk_sum_d[CHUNK-1:0];
          carry_q                        <= chunk_sum_d[CHUNK];
          if (cnt_q == CW'(NCH - 1)) begin
            res_q[W+1]  <= chunk_sum_d[CHUNK];
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign res       = res_q;

endmodule

// File: tb/tb_adlv_cpa_seq.sv
// Directed-vector and scoreboard bench for adlv_cpa_seq (res = s + 2e).
module tb_adlv_cpa_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [22:0] s_in;
  logic [22:0] e_in;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] res;
  logic        busy;

  int unsigned errors = 0;
  int unsigned checks = 0;

  adlv_cpa_seq #(.W(23), .CHUNK(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s_in      (s_in),
    .e_in      (e_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [22:0] s;
    logic [22:0] e;
    logic [24:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One full transaction. stall = DONE cycles with out_ready low;
  // junk = keep in_valid high with unrelated data after the accept.
  task automatic run_txn(input logic [22:0] s, input logic [22:0] e,
                         input logic [24:0] exp, input string name,
                         input int unsigned gap, input int unsigned stall,
                         input bit junk);
    int unsigned n;
    out_ready = (stall == 0);
    repeat (gap) tick();
    s_in = s;
    e_in = e;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) chk({name, "_accept_timeout"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = junk;
    s_in = 23'($urandom);
    e_in = 23'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_latency"}, n, 32'd3);
    chk({name, "_res"}, 32'(res), 32'(exp));
    for (int unsigned i = 0; i < stall; i++) begin
      tick();
      chk({name, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({name, "_hold_res"}, 32'(res), 32'(exp));
      chk({name, "_hold_iready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({name, "_ovalid_fall"}, 32'(out_valid), 32'd0);
    chk({name, "_iready_rise"}, 32'(in_ready), 32'd1);
    chk({name, "_busy_fall"}, 32'(busy), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [22:0] rs;
    logic [22:0] re;
    logic [24:0] rexp;

    vecs[0] = '{23'h000001, 23'h000000, 25'h0000001, "basic"};
    vecs[1] = '{23'h0000FF, 23'h000001, 25'h0000101, "chunk_carry"};
    vecs[2] = '{23'h7FFFFF, 23'h7FFFFF, 25'h17FFFFD, "max"};
    vecs[3] = '{23'h000000, 23'h000000, 25'h0000000, "zero"};
    vecs[4] = '{23'h000000, 23'h7FFFFF, 25'h0FFFFFE, "e_only"};
    vecs[5] = '{23'h7FFFFF, 23'h000000, 25'h07FFFFF, "s_only"};
    vecs[6] = '{23'h0000FF, 23'h000080, 25'h00001FF, "low_mix"};
    vecs[7] = '{23'h123456, 23'h00ABCD, 25'h0138BF0, "mixed"};
    vecs[8] = '{23'h400000, 23'h400000, 25'h0C00000, "top_bits"};
    vecs[9] = '{23'h00FFFF, 23'h000001, 25'h0010001, "two_chunk_ripple"};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    s_in = '0;
    e_in = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_res", 32'(res), 32'd0);

    tick();
    chk("idle_hold", 32'(busy), 32'd0);

    for (int unsigned i = 0; i < 10; i++)
      run_txn(vecs[i].s, vecs[i].e, vecs[i].exp, vecs[i].name, 0, 0, 1'b0);

    // Backpressure with new data offered during RUN and DONE.
    run_txn(23'h0ABCDE, 23'h012345, 25'h00D0368, "backpressure", 1, 5, 1'b1);
    tick();
    chk("bp_no_extra_accept", 32'(busy), 32'd0);
    chk("bp_res_kept", 32'(res), 32'h00D0368);

    // Reset during the second RUN cycle aborts the transaction.
    s_in = 23'h7FFFFF;
    e_in = 23'h7FFFFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("midrun_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    for (int unsigned i = 0; i < 5; i++) begin
      tick();
      chk("abort_no_output", 32'(out_valid), 32'd0);
    end
    run_txn(23'h123456, 23'h00ABCD, 25'h0138BF0, "after_abort", 0, 0, 1'b0);

    // Reset while parked in DONE.
    s_in = 23'h000010;
    e_in = 23'h000010;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("done_parked", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("done_abort_valid", 32'(out_valid), 32'd0);
    chk("done_abort_ready", 32'(in_ready), 32'd1);

    for (int unsigned i = 0; i < 40; i++) begin
      rs = 23'($urandom);
      re = 23'($urandom);
      rexp = 25'(rs) + (25'(re) << 1);
      run_txn(rs, re, rexp, "random", $urandom_range(0, 3), $urandom_range(0, 3),
              1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
